// File: rtl/tdm_defs.sv
// tdm_defs: shared channel count, select width and FSM states for the TDM mux
package tdm_defs;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  typedef enum logic {S_IDLE, S_SEND} state_t;
endpackage

// File: rtl/tdm_next_ch.sv
// tdm_next_ch: lowest-set-bit finder over the remaining channel mask
module tdm_next_ch
  import tdm_defs::*;
(
  input  logic [N_CH-1:0]  mask_i,
  output logic [SEL_W-1:0] index_o,
  output logic             found_o,
  output logic             is_last_o
);
  always_comb begin
    index_o = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (mask_i[i]) index_o = SEL_W'(i);
  end
  assign found_o   = |mask_i;
  // clearing the lowest set bit leaves zero only when exactly one bit was set
  assign is_last_o = found_o && ((mask_i & (mask_i - N_CH'(1))) == '0);
endmodule

// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: 8-channel TDM serializer emitting enabled channel words one per cycle with sel/valid/sync/done
module tdm_mux_8x1
  import tdm_defs::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic [N_CH-1:0]       en,
  output logic                  ready,
  output logic [WIDTH-1:0]      y,
  output logic [SEL_W-1:0]      sel,
  output logic                  valid,
  output logic                  sync,
  output logic                  done
);
  state_t                  state_q, state_d;
  logic [N_CH*WIDTH-1:0]   data_q, data_d;
  logic [N_CH-1:0]         rem_q, rem_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    valid_q, valid_d, sync_q, sync_d, done_q, done_d;
  logic                    accept, found, is_last;
  logic [N_CH-1:0]         mask;
  logic [N_CH*WIDTH-1:0]   src;
  logic [SEL_W-1:0]        idx;
  logic [WIDTH-1:0]        word;
  // rem_q holds channels still owed; empty while SEND means the current beat is the last
  assign ready  = (state_q == S_IDLE) || (rem_q == '0);
  assign accept = load && ready;
  // on accept the first beat is chosen straight from the incoming mask/data
  assign mask   = accept ? en : rem_q;
  assign src    = accept ? d : data_q;
  assign word   = src[idx*WIDTH +: WIDTH];
  tdm_next_ch u_next (
    .mask_i    (mask),
    .index_o   (idx),
    .found_o   (found),
    .is_last_o (is_last)
  );
  always_comb begin
    state_d = found ? S_SEND : S_IDLE;
    data_d  = accept ? d : data_q;
    rem_d   = mask & ~(N_CH'(1) << idx);
    y_d     = found ? word : y_q;
    sel_d   = found ? idx : sel_q;
    valid_d = found;
    sync_d  = accept && found;
    done_d  = is_last || (accept && !found);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end
  end
  assign y     = y_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign sync  = sync_q;
  assign done  = done_q;
endmodule

// File: tb/tb_tdm_mux_8x1.sv
// tb_tdm_mux_8x1: directed checks of the TDM mux (WIDTH=1) plus a WIDTH=4 demux loopback
module tb_tdm_mux_8x1;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  d = '0;
  logic [7:0]  en = '0;
  logic        ready, y, valid, sync, done;
  logic [2:0]  sel;
  logic        load4 = 1'b0;
  logic [31:0] d4 = '0;
  logic [7:0]  en4 = '0;
  logic        ready4, valid4, sync4, done4;
  logic [3:0]  y4;
  logic [2:0]  sel4;
  logic [3:0]  demux_out [8];
  int          n_checks = 0;
  int          n_fails = 0;

  always #5 clk = ~clk;

  tdm_mux_8x1 #(.WIDTH(1)) dut (
    .clk(clk), .rst(rst), .load(load), .d(d), .en(en), .ready(ready),
    .y(y), .sel(sel), .valid(valid), .sync(sync), .done(done)
  );

  tdm_mux_8x1 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .load(load4), .d(d4), .en(en4), .ready(ready4),
    .y(y4), .sel(sel4), .valid(valid4), .sync(sync4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input logic v, input int s, input logic yv,
                      input logic sy, input logic dn, input logic rdy);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".sel"},   32'(sel),   32'(s));
    chk({tag, ".y"},     32'(y),     32'(yv));
    chk({tag, ".sync"},  32'(sync),  32'(sy));
    chk({tag, ".done"},  32'(done),  32'(dn));
    chk({tag, ".ready"}, 32'(ready), 32'(rdy));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // checks 8 beats of a full-mask frame; optionally raises load with new data at beat load_at
  task automatic full_frame(input string tag, input logic [7:0] yv, input int load_at, input logic [7:0] nd);
    for (int k = 0; k < 8; k++) begin
      beat($sformatf("%s[%0d]", tag, k), 1'b1, k, yv[k], k == 0, k == 7, k == 7);
      if (k == load_at) begin
        load = 1'b1;
        d    = nd;
      end
      if (k < 7) begin
        step();
        load = 1'b0;
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 beat("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    // full frame; d is scrambled after accept to prove it was captured
    load = 1'b1; d = 8'b1011_0001; en = 8'hFF;
    step();
    load = 1'b0; d = 8'h00; en = 8'h00;
    full_frame("full", 8'b1011_0001, -1, 8'h00);
    step();
    beat("full.idle", 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1);

    // sparse mask: channels 1 and 7 back to back
    load = 1'b1; d = 8'hFF; en = 8'b1000_0010;
    step();
    load = 1'b0;
    beat("sparse.b0", 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    beat("sparse.b1", 1'b1, 7, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    beat("sparse.idle", 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1);

    // back-to-back frames chained on the last beat
    load = 1'b1; d = 8'hFF; en = 8'hFF;
    step();
    load = 1'b0;
    full_frame("b2b1", 8'hFF, 7, 8'h0F);
    step();
    load = 1'b0; d = 8'h00;
    full_frame("b2b2", 8'h0F, -1, 8'h00);
    step();
    beat("b2b.idle", 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1);

    // empty mask: no beats, a single done pulse, outputs hold
    load = 1'b1; d = 8'hFF; en = 8'h00;
    step();
    load = 1'b0;
    beat("empty.done", 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    beat("empty.after", 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1);

    // load during beat 3 is ignored, frame keeps its captured data
    load = 1'b1; d = 8'hFF; en = 8'hFF;
    step();
    load = 1'b0;
    full_frame("ign", 8'hFF, 3, 8'h00);
    step();
    beat("ign.idle", 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("ign.no_extra", 32'(valid), 32'd0);

    // asynchronous reset during beat 4
    load = 1'b1; d = 8'hFF; en = 8'hFF;
    step();
    load = 1'b0;
    repeat (4) step();
    chk("rst.pre_sel", 32'(sel), 32'd4);
    #2 rst = 1'b1;
    #1 beat("rst.async", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    beat("rst.held", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    load = 1'b1; d = 8'hA5; en = 8'hFF;
    step();
    load = 1'b0;
    full_frame("post", 8'hA5, -1, 8'h00);
    step();

    // WIDTH=4 loopback through a bench-side 1x8 demux
    for (int k = 0; k < 8; k++) demux_out[k] = 4'hF;
    load4 = 1'b1; d4 = 32'h7654_3210; en4 = 8'hFF;
    step();
    load4 = 1'b0; d4 = '0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("loop.valid[%0d]", k), 32'(valid4), 32'd1);
      if (valid4) demux_out[sel4] = y4;
      step();
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("loop.out[%0d]", k), 32'(demux_out[k]), 32'(k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
